// File: rtl/sha3_absorb_feeder_pkg.sv
// Shared definitions for the SHA3 absorb feeder: FSM encoding, Keccak rate constants
// and the CLOG2 sizing macro used for address widths.
`ifndef CLOG2
`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package sha3_absorb_feeder_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAITH = 3'd2,
    ST_DONE  = 3'd3
  } feeder_state_e;

  // Keccak-f[1600] rate for the SHA3 variants the core may be configured for
  localparam int unsigned SHA3_256_RATE_BITS = 1088;
  localparam int unsigned SHA3_512_RATE_BITS = 576;

  function automatic int unsigned rate_words(input int unsigned word_w, input logic is_512);
    return (is_512 ? SHA3_512_RATE_BITS : SHA3_256_RATE_BITS) / word_w;
  endfunction

endpackage

// File: rtl/sha3_absorb_feeder_fifo2.sv
// Two-entry skid FIFO between the RAM read port and the Keccak absorb port.
// Head entry is held stable until popped; simultaneous push/pop keeps the count.
module feeder_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         vld_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         vld_q;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_data_i;
        else               ent1_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
      vld_q  <= (cnt_d != 2'd0);
    end
  end

  assign head_o = ent0_q;
  assign vld_o  = vld_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sha3_absorb_feeder.sv
// Start/done responder that streams E from word RAM into the Keccak absorb port,
// waits for the digest and returns a one-cycle done pulse.
module sha3_absorb_feeder
  import sha3_absorb_feeder_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned N_WORDS   = 16,
  parameter int unsigned ADDR_W    = `CLOG2(N_WORDS),
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              absorb_valid,
  output logic [WORD_W-1:0] absorb_data,
  output logic              absorb_last,
  input  logic              absorb_ready,
  input  logic              hash_valid
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(N_WORDS);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  feeder_state_e     state_q;
  logic [CNT_W-1:0]  rd_cnt_q, tx_cnt_q;
  logic              inflight_q, inflight_last_q;
  logic              done_q, busy_q;

  logic              fire, rd_go;
  logic              fifo_vld;
  logic [1:0]        fifo_cnt;
  logic [WORD_W:0]   fifo_head;
  logic [2:0]        occupancy;

  assign fire      = fifo_vld && absorb_ready;
  assign occupancy = 3'(fifo_cnt) + 3'(inflight_q);
  // Issue only if the word will still have a FIFO slot once it returns next cycle
  assign rd_go     = (state_q == ST_FETCH) && (rd_cnt_q < N_CNT) &&
                     (occupancy < (3'd2 + 3'(fire)));

  feeder_fifo2 #(.W(WORD_W + 1)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, mem_rdata}),
    .pop_i       (fire),
    .head_o      (fifo_head),
    .vld_o       (fifo_vld),
    .cnt_o       (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rd_cnt_q        <= '0;
      tx_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      inflight_q      <= rd_go;
      inflight_last_q <= rd_go && (rd_cnt_q == LAST_IDX);
      done_q          <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_FETCH;
            rd_cnt_q <= '0;
            tx_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (rd_go) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          if (fire) begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            if (tx_cnt_q == LAST_IDX) state_q <= ST_WAITH;
          end
        end
        ST_WAITH: begin
          if (hash_valid) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done         = done_q;
  assign busy         = busy_q;
  assign mem_rd_en    = rd_go;
  assign mem_addr     = rd_go ? (BASE + ADDR_W'(rd_cnt_q)) : '0;
  assign absorb_valid = fifo_vld;
  assign absorb_data  = fifo_head[WORD_W-1:0];
  assign absorb_last  = fifo_vld && fifo_head[WORD_W];

endmodule

// File: tb/tb_sha3_absorb_feeder.sv
// Randomized bench for sha3_absorb_feeder: a transaction-level model of the
// start/stream/digest/done protocol checks every cycle of a 16-word and a 1-word instance.
module tb_sha3_absorb_feeder;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned N_WORDS   = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned BASE_ADDR = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-word instance
  logic              start, done, busy, rd_en, av, al, ar, hv;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] rdata, ad;
  logic [WORD_W-1:0] ram [N_WORDS];

  // 1-word instance
  logic              b_start, b_done, b_busy, b_rd_en, b_av, b_al, b_ar, b_hv;
  logic [0:0]        b_addr;
  logic [WORD_W-1:0] b_rdata, b_ad, b_word;

  sha3_absorb_feeder #(.WORD_W(WORD_W), .N_WORDS(N_WORDS), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
    .mem_rd_en(rd_en), .mem_addr(addr), .mem_rdata(rdata),
    .absorb_valid(av), .absorb_data(ad), .absorb_last(al), .absorb_ready(ar),
    .hash_valid(hv)
  );

  sha3_absorb_feeder #(.WORD_W(WORD_W), .N_WORDS(1), .ADDR_W(1), .BASE_ADDR(0)) dut_n1 (
    .clk(clk), .rst(rst), .start(b_start), .done(b_done), .busy(b_busy),
    .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .absorb_valid(b_av), .absorb_data(b_ad), .absorb_last(b_al), .absorb_ready(b_ar),
    .hash_valid(b_hv)
  );

  // Synchronous-read RAMs: data valid the cycle after the strobe
  always @(posedge clk) if (rd_en) rdata <= ram[addr];
  always @(posedge clk) if (b_rd_en) b_rdata <= (b_addr == 1'b0) ? b_word : ~b_word;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Protocol model: 0 idle, 1 streaming, 2 awaiting digest, 3 done pulse
  int          m_phase   = 0;
  int          m_reads   = 0;
  int          m_fires   = 0;
  int          m_run_cyc = 0;
  int          m_last_run = 0;
  logic        m_fire;
  logic        prev_stall = 1'b0;
  logic        prev_l;
  logic [WORD_W-1:0] prev_d;

  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_done", done, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rd_en", rd_en, 0);
      check_eq("rst_addr", addr, 0);
      check_eq("rst_valid", av, 0);
      check_eq("rst_data", ad, 0);
      check_eq("rst_last", al, 0);
      m_phase    = 0;
      prev_stall = 1'b0;
    end else begin
      m_fire = av && ar;
      check_eq("busy", busy, (m_phase == 1) || (m_phase == 2));
      check_eq("done", done, m_phase == 3);
      if (m_phase != 1) begin
        check_eq("rd_outside_fetch", rd_en, 0);
        check_eq("valid_outside_fetch", av, 0);
      end
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_reads = 0; m_fires = 0; m_run_cyc = 0;
        end
        1: begin
          m_run_cyc++;
          if (m_run_cyc == 1) check_eq("first_read", rd_en, 1);
          if (m_run_cyc <= 2) check_eq("early_valid", av, 0);
          if (m_run_cyc == 3) check_eq("first_valid", av, 1);
          if (prev_stall) begin
            check_eq("stall_valid", av, 1);
            check_eq("stall_data", ad, prev_d);
            check_eq("stall_last", al, prev_l);
          end
          if (rd_en) begin
            check_eq("rd_addr", addr, 64'((BASE_ADDR + m_reads) % N_WORDS));
            m_reads++;
          end
          if (m_fire) begin
            check_eq("fire_in_range", m_fires < N_WORDS, 1);
            if (m_fires < N_WORDS) begin
              check_eq("absorb_data", ad, ram[m_fires]);
              check_eq("absorb_last", al, m_fires == N_WORDS - 1);
            end
            m_fires++;
          end
          check_eq("buffered_le2", (m_reads - m_fires) <= 2, 1);
          check_eq("reads_le_n", m_reads <= N_WORDS, 1);
          if (m_fire && m_fires == N_WORDS) begin
            m_last_run = m_run_cyc;
            m_phase    = 2;
          end
        end
        2: if (hv) m_phase = 3;
        default: begin
          check_eq("reads_total", m_reads, N_WORDS);
          check_eq("fires_total", m_fires, N_WORDS);
          m_phase = 0;
        end
      endcase
      prev_stall = av && !ar;
      prev_d     = ad;
      prev_l     = al;
    end
  end

  // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random; rst_at: fires before reset (-1 none)
  task automatic run_op(input int rmode, input bit stray, input bit hold, input int rst_at);
    int cyc;
    int dly;
    bit quit;
    cyc  = 0;
    quit = 1'b0;
    dly  = int'($urandom_range(0, 3));
    hv   = hold;
    ar   = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!done && !quit && cyc < 400) begin
      case (rmode)
        0:       ar = 1'b1;
        1:       ar = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: ar = 1'($urandom_range(0, 1));
      endcase
      if (stray) start = ($urandom_range(0, 2) == 0);
      if (!hold && m_phase == 2) begin
        if (dly == 0) hv = 1'b1;
        else dly--;
      end
      if (rst_at >= 0 && m_phase == 1 && m_fires == rst_at) begin
        rst = 1'b1; start = 1'b0; ar = 1'b0; quit = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end else begin
        @(posedge clk); #1 cyc++;
      end
    end
    if (!quit) check_eq("op_done_seen", done, 1);
    start = stray && !quit;
    hv    = 1'b0;
    ar    = 1'b0;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic fill_ram_random();
    for (int i = 0; i < N_WORDS; i++) ram[i] = $urandom;
  endtask

  initial begin
    int cnt, b_reads, b_fires;
    logic [WORD_W-1:0] b_got;
    logic b_got_l;
    start = 1'b0; ar = 1'b0; hv = 1'b0;
    b_start = 1'b0; b_ar = 1'b0; b_hv = 1'b0; b_word = '0;
    for (int i = 0; i < N_WORDS; i++) ram[i] = WORD_W'(32'hA0 + i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full-rate stream of A0..AF: last word fires in the 18th streaming cycle
    run_op(0, 1'b0, 1'b0, -1);
    check_eq("t1_last_fire_cycle", m_last_run, 18);

    fill_ram_random();
    run_op(1, 1'b0, 1'b0, -1);
    fill_ram_random();
    run_op(2, 1'b1, 1'b0, -1);
    run_op(1, 1'b1, 1'b0, -1);

    // Reset while word 7 is pending, then a complete restart
    fill_ram_random();
    run_op(1, 1'b0, 1'b0, 7);
    check_eq("t4_idle_after_rst", busy, 0);
    run_op(2, 1'b0, 1'b0, -1);

    // Digest already valid before start
    run_op(0, 1'b0, 1'b1, -1);
    run_op(2, 1'b1, 1'b1, -1);

    for (int k = 0; k < 4; k++) begin
      fill_ram_random();
      run_op(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    // Single-word instance
    b_word = $urandom;
    b_ar   = 1'b1;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    b_reads = 0; b_fires = 0; cnt = 0;
    b_got = '0; b_got_l = 1'b0;
    while (b_fires == 0 && cnt < 20) begin
      @(negedge clk);
      if (b_rd_en) b_reads++;
      if (b_av && b_ar) begin
        b_fires++;
        b_got   = b_ad;
        b_got_l = b_al;
      end
      cnt++;
    end
    check_eq("n1_fires", b_fires, 1);
    check_eq("n1_reads", b_reads, 1);
    check_eq("n1_data", b_got, b_word);
    check_eq("n1_last", b_got_l, 1);
    @(posedge clk); #1 b_hv = 1'b1;
    @(negedge clk);
    check_eq("n1_done_early", b_done, 0);
    check_eq("n1_busy_wait", b_busy, 1);
    @(posedge clk); #1 b_hv = 1'b0;
    @(negedge clk);
    check_eq("n1_done", b_done, 1);
    check_eq("n1_busy_done", b_busy, 0);
    @(negedge clk);
    check_eq("n1_done_pulse", b_done, 0);
    check_eq("n1_no_extra_read", b_rd_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
